iter_mdu: RTL

Parametrised, multi-cycle RISC-V M-extension multiply/divide unit. It replaces the single-cycle combinational mul/div path with a shift-add multiplier and a restoring divider that share one iteration datapath. The unit sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on `in_ready`/`out_valid` instead of closing timing through a 128-bit multiplier. Flush support allows cancellation on redirect.

---
 rtl/iter_mdu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/iter_mdu.sv
// Multi-cycle RISC-V M-extension unit: shift-add multiplier and restoring divider sharing one adder.
// Define ITER_MDU_WORD_EN to add the RV64 word operations (MULW, DIVW, DIVUW, REMW, REMUW).
module iter_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic              is_mul, hi_sel, rem_sel, neg;
    logic [2*XLEN-1:0] acc, mc;
    logic [XLEN-1:0]   mq;

    logic [2:0]        f3;
    logic              w_op, w_ok;
    logic [XLEN-1:0]   a_x, b_x, min_val, m1, m2, spec_res;
    logic              s1_signed, s2_signed, n1, n2, div_zero, ovf, undef, special;

    assign f3       = op[2:0];
    assign in_ready = (state == IDLE) && !flush && !reset;

`ifdef ITER_MDU_WORD_EN
    logic word;
    assign w_op = op[3];
    assign w_ok = (f3 == 3'd0) || f3[2];

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return XLEN'($signed(v[31:0]));
    endfunction
`else
    assign w_op = 1'b0;
    assign w_ok = 1'b0;
`endif

    // Request decode: operand extension, magnitudes and the special cases that skip iteration.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        a_x     = src1;
        b_x     = src2;
        min_val = {1'b1, {(XLEN-1){1'b0}}};
`ifdef ITER_MDU_WORD_EN
        if (w_op) begin
            if (f3[0]) begin
                a_x = XLEN'(src1[31:0]);
                b_x = XLEN'(src2[31:0]);
            end else begin
                a_x = XLEN'($signed(src1[31:0]));
                b_x = XLEN'($signed(src2[31:0]));
            end
            min_val = {{(XLEN-31){1'b1}}, 31'b0};
        end
`endif
        s1_signed = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        s2_signed = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        n1        = s1_signed && a_x[XLEN-1];
        n2        = s2_signed && b_x[XLEN-1];
        m1        = n1 ? -a_x : a_x;
        m2        = n2 ? -b_x : b_x;

        undef    = op[3] && !w_ok;
        div_zero = f3[2] && (b_x == '0);
        ovf      = ((f3 == 3'd4) || (f3 == 3'd6)) && (a_x == min_val) && (&b_x);
        special  = undef || div_zero || ovf;

        if (undef)         spec_res = '0;
        else if (div_zero) spec_res = f3[1] ? a_x : '1;
        else               spec_res = f3[1] ? '0 : a_x;
`ifdef ITER_MDU_WORD_EN
        if (w_op) spec_res = sext32(spec_res);
`endif
    end

    // Shared iteration step: accumulate for multiply, trial-subtract for divide.
    logic [2*XLEN-1:0] add_a, add_b, sum, acc_nxt, raw, fixed;
    logic [XLEN-1:0]   mq_nxt, pick, fin;

    always_comb begin
        add_a = is_mul ? acc : {{(XLEN-1){1'b0}}, acc[XLEN-1:0], mq[XLEN-1]};
        add_b = is_mul ? mc : ~mc;
        sum   = add_a + add_b + {{(2*XLEN-1){1'b0}}, ~is_mul};
        if (is_mul) begin
            acc_nxt = mq[0] ? sum : acc;
            mq_nxt  = mq >> 1;
        end else begin
            acc_nxt = sum[2*XLEN-1] ? add_a : sum;
            mq_nxt  = {mq[XLEN-2:0], ~sum[2*XLEN-1]};
        end

        if (is_mul)       raw = acc_nxt;
        else if (rem_sel) raw = {{XLEN{1'b0}}, acc_nxt[XLEN-1:0]};
        else              raw = {{XLEN{1'b0}}, mq_nxt};
        fixed = neg ? -raw : raw;
        pick  = hi_sel ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
        fin   = pick;
`ifdef ITER_MDU_WORD_EN
        if (word) fin = sext32(pick);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            out_valid <= 1'b0;
            count     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (special) begin
                        result    <= spec_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= w_op ? CW'(32) : CW'(XLEN);
                        state <= CALC;
                    end
                end
                CALC: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        result    <= fin;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clock) begin
        if (state == IDLE && in_valid) begin
            is_mul  <= !f3[2];
            hi_sel  <= !f3[2] && (f3 != 3'd0);
            rem_sel <= f3[1];
            neg     <= (f3[2] && f3[1]) ? n1 : (n1 ^ n2);
            acc     <= '0;
            if (!f3[2]) begin
                mc <= {{XLEN{1'b0}}, m1};
                mq <= m2;
            end else begin
                mc <= {{XLEN{1'b0}}, m2};
                mq <= w_op ? (m1 << (XLEN - 32)) : m1;
            end
`ifdef ITER_MDU_WORD_EN
            word <= w_op;
`endif
        end else if (state == CALC) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            if (is_mul) mc <= mc << 1;
        end
    end

endmodule
